grf_writeback: RTL

- General-purpose register file for the pipelined MIPS core, sitting at the W stage write-back boundary.
- The write port is the one-to-many counterpart of the operand-select muxes. It decodes a 5-bit address and routes one 32-bit write-back value into exactly one of 31 architectural registers.
- Two combinational read ports feed the D stage, with optional internal write-through bypass.
- A registered write trace records every committed write for the test harness.

---
 rtl/grf_writeback_if.sv | 34 +++
 rtl/grf_writeback.sv | 78 +++++++
 2 files changed

// File: rtl/grf_writeback_if.sv
// Bus bundle for the write-back register file.
// The master side (the W/D pipeline stages or a bench) drives the write port
// and the read addresses. The slave side (the register file) returns the read
// data and the registered write trace.
//   we/wa/wd/wpc        : write enable, address, data, PC of the writer
//   ra1/ra2 -> rd1/rd2  : two combinational read ports
//   trace_*             : one-cycle record of each committed write
interface grf_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [31:0]       wpc;
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              trace_valid;
    logic [31:0]       trace_pc;
    logic [ADDR_W-1:0] trace_addr;
    logic [DATA_W-1:0] trace_data;

    modport master (
        output we, wa, wd, wpc, ra1, ra2,
        input  rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data
    );

    modport slave (
        input  we, wa, wd, wpc, ra1, ra2,
        output rd1, rd2, trace_valid, trace_pc, trace_addr, trace_data
    );
endinterface

// File: rtl/grf_writeback.sv
// General-purpose register file at the W-stage write-back boundary.
// One write port decodes wa and stores wd into one of registers 1..2**ADDR_W-1
// (register 0 has no storage and always reads 0). Two combinational read ports
// serve the D stage, with optional write-through forwarding (BYPASS=1).
// Every committed write is echoed one cycle later on the trace outputs.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high; clears registers and trace, beats we
//   bus   : grf_writeback_if slave (write port, read ports, trace)
module grf_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic           clk,
    input  logic           reset,
    grf_writeback_if.slave bus
);
    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam bit          BYP  = (BYPASS != 0);

    // Entry 0 is deliberately absent from the storage array.
    logic [DATA_W-1:0] regs [1:NREG-1];

    logic commit;
    assign commit = bus.we && (bus.wa != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 1; i < NREG; i++) begin
                regs[i[ADDR_W-1:0]] <= '0;
            end
        end else if (commit) begin
            regs[bus.wa] <= bus.wd;
        end
    end

    // Trace payload holds its last value when no write commits; only
    // trace_valid drops back to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.trace_valid <= 1'b0;
            bus.trace_pc    <= '0;
            bus.trace_addr  <= '0;
            bus.trace_data  <= '0;
        end else if (commit) begin
            bus.trace_valid <= 1'b1;
            bus.trace_pc    <= bus.wpc;
            bus.trace_addr  <= bus.wa;
            bus.trace_data  <= bus.wd;
        end else begin
            bus.trace_valid <= 1'b0;
        end
    end

    // Forwarding depends on we only, so it stays active while reset is high.
    always_comb begin
        bus.rd1 = '0;
        if (bus.ra1 != '0) begin
            if (BYP && bus.we && (bus.wa == bus.ra1)) begin
                bus.rd1 = bus.wd;
            end else begin
                bus.rd1 = regs[bus.ra1];
            end
        end
    end

    always_comb begin
        bus.rd2 = '0;
        if (bus.ra2 != '0) begin
            if (BYP && bus.we && (bus.wa == bus.ra2)) begin
                bus.rd2 = bus.wd;
            end else begin
                bus.rd2 = regs[bus.ra2];
            end
        end
    end
endmodule
